tof_meter: RTL and testbench

- Downstream consumer of the m-sequence correlator's `peak_found` output.
- On each `start` (the same pulse that launches the transmitted sequence), counts clock cycles until the correlator reports a peak. The result is the time of flight.
- Suppresses a blanking window that covers direct transmit coupling, and flags a timeout if no echo arrives.
- Presents the result through a valid/ready handshake to the display/readout logic.

---
 rtl/tof_pkg.sv | 7 +
 rtl/tof_counter.sv | 20 ++
 rtl/tof_meter.sv | 71 +++++++
 tb/tb_tof_meter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// tof_pkg: shared state encoding and default sizing for the time-of-flight meter
package tof_pkg;
    localparam int CNT_W        = 16;
    localparam int BLANK_CYCLES = 8;
    localparam int TIMEOUT      = 1000;
    typedef enum logic [1:0] {IDLE, BLANK, MEASURE, DONE} tof_state_t;
endpackage

// File: rtl/tof_counter.sv
// tof_counter: cycle up-counter with synchronous clear/enable and an equality compare
module tof_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] count,
    output logic             count_eq
);
    // clear wins over enable so a reset or new launch always restarts from zero
    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
    assign count_eq = (count == cmp);
endmodule

// File: rtl/tof_meter.sv
// tof_meter: measures cycles from start to the first unblanked correlator peak
module tof_meter #(
    parameter int CNT_W        = tof_pkg::CNT_W,
    parameter int BLANK_CYCLES = tof_pkg::BLANK_CYCLES,
    parameter int TIMEOUT      = tof_pkg::TIMEOUT
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             peak_found,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] tof,
    output logic             timeout
);
    import tof_pkg::*;
    tof_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, cmp;
    logic             count_eq, launch, capture;
    // count holds N-1 before edge N, so boundaries compare one below and tof is count+1
    assign launch  = (state == IDLE) && start;
    assign capture = (state == MEASURE) && (peak_found || count_eq);
    assign cmp     = (state == BLANK) ? CNT_W'(BLANK_CYCLES - 1) : CNT_W'(TIMEOUT - 1);
    tof_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .clear    (Rst || launch),
        .en       ((state == BLANK) || (state == MEASURE)),
        .cmp      (cmp),
        .count    (count),
        .count_eq (count_eq)
    );
    // state register
    always_ff @(posedge clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // next-state: blanking, then measuring until a peak or the timeout boundary
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? BLANK : IDLE;
            BLANK:   state_nxt = count_eq ? MEASURE : BLANK;
            MEASURE: state_nxt = capture ? DONE : MEASURE;
            DONE:    state_nxt = result_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // registered outputs; a peak on the timeout edge still counts as a real echo
    always_ff @(posedge clk) begin
        if (Rst) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            tof          <= '0;
            timeout      <= 1'b0;
        end else begin
            if (launch)
                busy <= 1'b1;
            if (capture) begin
                busy         <= 1'b0;
                result_valid <= 1'b1;
                tof          <= count + 1'b1;
                timeout      <= !peak_found;
            end
            if ((state == DONE) && result_ready)
                result_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tof_meter.sv
// tb_tof_meter: directed vectors and corner sequences for tof_meter
module tb_tof_meter;
    localparam int CNT_W = 8;
    localparam int BLANK_CYCLES = 4;
    localparam int TIMEOUT = 20;
    logic             clk = 1'b0;
    logic             Rst = 1'b1;
    logic             start = 1'b0;
    logic             peak_found = 1'b0;
    logic             result_ready = 1'b0;
    logic             busy, result_valid, timeout;
    logic [CNT_W-1:0] tof;
    int               n_chk = 0;
    int               n_fail = 0;
    typedef struct {
        int p1;
        int p2;
        int exp_tof;
        int exp_to;
        int hold;
    } vec_t;
    vec_t vecs[6];
    tof_meter #(.CNT_W(CNT_W), .BLANK_CYCLES(BLANK_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .Rst          (Rst),
        .start        (start),
        .peak_found   (peak_found),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .tof          (tof),
        .timeout      (timeout)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_tof"}, int'(tof), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask
    task automatic run_meas(input vec_t v);
        int cap = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_e0", int'(busy), 1);
        for (int e = 1; e <= 40 && cap < 0; e++) begin
            peak_found = (e == v.p1) || (e == v.p2);
            step();
            peak_found = 1'b0;
            if (result_valid)
                cap = e;
            else
                chk("busy_meas", int'(busy), 1);
        end
        chk("capture_edge", cap, v.exp_tof);
        chk("busy_done", int'(busy), 0);
        chk("tof", int'(tof), v.exp_tof);
        chk("timeout", int'(timeout), v.exp_to);
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_tof", int'(tof), v.exp_tof);
            chk("hold_timeout", int'(timeout), v.exp_to);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("accept_valid", int'(result_valid), 0);
        chk("accept_busy", int'(busy), 0);
        chk("accept_tof_kept", int'(tof), v.exp_tof);
        chk("accept_timeout_kept", int'(timeout), v.exp_to);
    endtask
    initial begin
        vecs[0] = '{p1: 10, p2: 0,  exp_tof: 10, exp_to: 0, hold: 5};
        vecs[1] = '{p1: 3,  p2: 12, exp_tof: 12, exp_to: 0, hold: 1};
        vecs[2] = '{p1: 0,  p2: 0,  exp_tof: 20, exp_to: 1, hold: 2};
        vecs[3] = '{p1: 20, p2: 0,  exp_tof: 20, exp_to: 0, hold: 2};
        vecs[4] = '{p1: 4,  p2: 5,  exp_tof: 5,  exp_to: 0, hold: 1};
        vecs[5] = '{p1: 2,  p2: 25, exp_tof: 20, exp_to: 1, hold: 0};
        Rst = 1'b1;
        start = 1'b1;
        peak_found = 1'b1;
        step();
        step();
        check_idle_zero("reset");
        Rst = 1'b0;
        start = 1'b0;
        peak_found = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_valid", int'(result_valid), 0);
        for (int i = 0; i < 6; i++) run_meas(vecs[i]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            start = (e == 2) || (e == 8);
            peak_found = (e == 9);
            step();
        end
        peak_found = 1'b0;
        chk("restart_valid", int'(result_valid), 1);
        chk("restart_tof", int'(tof), 9);
        chk("restart_timeout", int'(timeout), 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_start_valid", int'(result_valid), 1);
            chk("done_start_busy", int'(busy), 0);
            chk("done_start_tof", int'(tof), 9);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("accept_start_valid", int'(result_valid), 0);
        chk("accept_start_busy", int'(busy), 0);
        step();
        start = 1'b0;
        chk("idle_start_busy", int'(busy), 1);
        chk("idle_start_valid", int'(result_valid), 0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check_idle_zero("cleanup");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        chk("mid_busy_pre", int'(busy), 1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check_idle_zero("mid_reset");
        for (int e = 8; e <= 14; e++) begin
            peak_found = (e == 10);
            step();
            chk("after_reset_busy", int'(busy), 0);
            chk("after_reset_valid", int'(result_valid), 0);
        end
        peak_found = 1'b0;
        chk("after_reset_tof", int'(tof), 0);
        run_meas('{p1: 6, p2: 0, exp_tof: 6, exp_to: 0, hold: 1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
